// File: rtl/queue_pkg.sv
// Shared sizing helpers for the queue family: pointer and occupancy widths
// derived from the entry count.
package queue_pkg;

  // One extra bit above the index so full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/flow_queue_if.sv
// Enqueue/dequeue valid-ready handshake bundle for flow_queue.
interface flow_queue_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] din;
  logic             enq_val;
  logic             enq_rdy;
  logic [WIDTH-1:0] dout;
  logic             deq_val;
  logic             deq_rdy;

  modport master (
    output din, enq_val, deq_rdy,
    input  enq_rdy, dout, deq_val
  );

  modport slave (
    input  din, enq_val, deq_rdy,
    output enq_rdy, dout, deq_val
  );

endinterface

// File: rtl/queue_ram.sv
// DEPTH x WIDTH storage with a synchronous write port and an asynchronous
// read port.
module queue_ram #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/flow_queue.sv
// Parametrised valid/ready FIFO with occupancy count, almost-full flag,
// synchronous flush and optional empty-bypass.
module flow_queue
  import queue_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 2,
  parameter int AFULL  = DEPTH - 1,
  parameter int BYPASS = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  flow_queue_if.slave                 q,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        almost_full
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_next;
  logic [PW-1:0]    rd_next;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic             enq_fire;
  logic             deq_fire;
  logic             pass_through;
  logic             do_write;
  logic             do_read;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign q.enq_rdy = !full && !flush;
  assign q.deq_val = (!empty || ((BYPASS != 0) && q.enq_val)) && !flush;
  assign q.dout    = ((BYPASS != 0) && empty) ? q.din : rd_data;

  assign enq_fire = q.enq_val && q.enq_rdy;
  assign deq_fire = q.deq_val && q.deq_rdy;

  // A word consumed in the same cycle it arrives at an empty queue never
  // touches storage or the pointers.
  assign pass_through = (BYPASS != 0) && empty && enq_fire && deq_fire;
  assign do_write     = enq_fire && !pass_through;
  assign do_read      = deq_fire && !pass_through;

  assign wr_next = do_write ? wr_ptr + PW'(1) : wr_ptr;
  assign rd_next = do_read  ? rd_ptr + PW'(1) : rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      count  <= CW'(wr_next - rd_next);
    end
  end

  assign almost_full = (count >= CW'(AFULL));

  queue_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (do_write),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (q.din),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_flow_queue.sv
// Drives three flow_queue configurations with shared stimulus and compares
// each against a shift-register queue model of the handshake rules.
module tb_flow_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [3:0] din;
  logic       enq_val;
  logic       deq_rdy;

  always #5 clk = ~clk;

  flow_queue_if #(.WIDTH(4)) if0 ();
  flow_queue_if #(.WIDTH(4)) if1 ();
  flow_queue_if #(.WIDTH(4)) if2 ();

  assign if0.din = din;  assign if0.enq_val = enq_val;  assign if0.deq_rdy = deq_rdy;
  assign if1.din = din;  assign if1.enq_val = enq_val;  assign if1.deq_rdy = deq_rdy;
  assign if2.din = din;  assign if2.enq_val = enq_val;  assign if2.deq_rdy = deq_rdy;

  logic [1:0] cnt0;
  logic [2:0] cnt1;
  logic [2:0] cnt2;
  logic       af0;
  logic       af1;
  logic       af2;

  flow_queue #(.WIDTH(4), .DEPTH(2), .AFULL(1), .BYPASS(0)) u_d2 (
    .clk(clk), .reset(reset), .flush(flush), .q(if0), .count(cnt0), .almost_full(af0)
  );
  flow_queue #(.WIDTH(4), .DEPTH(4), .AFULL(3), .BYPASS(0)) u_d4 (
    .clk(clk), .reset(reset), .flush(flush), .q(if1), .count(cnt1), .almost_full(af1)
  );
  flow_queue #(.WIDTH(4), .DEPTH(4), .AFULL(3), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .flush(flush), .q(if2), .count(cnt2), .almost_full(af2)
  );

  logic       obs_rdy  [3];
  logic       obs_val  [3];
  logic [3:0] obs_dout [3];
  logic [2:0] obs_cnt  [3];
  logic       obs_af   [3];

  assign obs_rdy[0] = if0.enq_rdy;  assign obs_val[0] = if0.deq_val;  assign obs_dout[0] = if0.dout;
  assign obs_rdy[1] = if1.enq_rdy;  assign obs_val[1] = if1.deq_val;  assign obs_dout[1] = if1.dout;
  assign obs_rdy[2] = if2.enq_rdy;  assign obs_val[2] = if2.deq_val;  assign obs_dout[2] = if2.dout;
  assign obs_cnt[0] = {1'b0, cnt0};
  assign obs_cnt[1] = cnt1;
  assign obs_cnt[2] = cnt2;
  assign obs_af[0]  = af0;
  assign obs_af[1]  = af1;
  assign obs_af[2]  = af2;

  // Reference: head at slot 0, contents shift down on every dequeue.
  int         m_depth [3] = '{2, 4, 4};
  int         m_afull [3] = '{1, 3, 3};
  bit         m_byp   [3] = '{1'b0, 1'b0, 1'b1};
  logic [3:0] m_q     [3][4];
  int         m_occ   [3];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rs, input logic fl, input logic ev,
                               input logic [3:0] d, input logic dr);
    logic e_rdy [3];
    logic e_val [3];
    logic ef;
    logic df;
    @(negedge clk);
    reset   = rs;
    flush   = fl;
    enq_val = ev;
    din     = d;
    deq_rdy = dr;
    #1;
    for (int i = 0; i < 3; i++) begin
      e_rdy[i] = (m_occ[i] != m_depth[i]) && !fl;
      e_val[i] = ((m_occ[i] != 0) || (m_byp[i] && ev)) && !fl;
      checkOutput($sformatf("u%0d_enq_rdy", i), 32'(obs_rdy[i]), 32'(e_rdy[i]));
      checkOutput($sformatf("u%0d_deq_val", i), 32'(obs_val[i]), 32'(e_val[i]));
      checkOutput($sformatf("u%0d_count", i), 32'(obs_cnt[i]), 32'(m_occ[i]));
      checkOutput($sformatf("u%0d_afull", i), 32'(obs_af[i]), 32'(m_occ[i] >= m_afull[i]));
      if (e_val[i]) begin
        checkOutput($sformatf("u%0d_dout", i), 32'(obs_dout[i]),
                    32'((m_occ[i] == 0) ? d : m_q[i][0]));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rs || fl) begin
        m_occ[i] = 0;
      end else begin
        ef = ev && e_rdy[i];
        df = e_val[i] && dr;
        if (!(m_byp[i] && (m_occ[i] == 0) && ef && df)) begin
          if (df) begin
            for (int k = 0; k < 3; k++) m_q[i][k] = m_q[i][k+1];
            m_occ[i]--;
          end
          if (ef) begin
            m_q[i][m_occ[i]] = d;
            m_occ[i]++;
          end
        end
      end
    end
  endtask

  initial begin
    int p_enq;
    int p_deq;
    reset   = 1'b1;
    flush   = 1'b0;
    enq_val = 1'b0;
    deq_rdy = 1'b0;
    din     = '0;
    for (int i = 0; i < 3; i++) m_occ[i] = 0;
    repeat (2) @(posedge clk);

    // Fill then drain: DEPTH=2 goes full after two words.
    applyStimulus(0, 0, 1, 4'd1, 0);
    applyStimulus(0, 0, 1, 4'd2, 0);
    applyStimulus(0, 0, 0, 4'd0, 0);
    applyStimulus(0, 0, 0, 4'd0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1);
    applyStimulus(0, 0, 0, 4'd0, 0);

    // Almost-full threshold and full on DEPTH=4.
    for (int k = 5; k <= 8; k++) applyStimulus(0, 0, 1, 4'(k), 0);
    applyStimulus(0, 0, 1, 4'd9, 0);
    repeat (5) applyStimulus(0, 0, 0, 4'd0, 1);

    // Wrap-around at steady occupancy two.
    applyStimulus(0, 0, 1, 4'd0, 0);
    applyStimulus(0, 0, 1, 4'd1, 0);
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 1, 4'(k + 2), 1);
    repeat (3) applyStimulus(0, 0, 0, 4'd0, 1);

    // Empty bypass, then a stored word when the consumer stalls.
    applyStimulus(0, 0, 1, 4'hA, 1);
    applyStimulus(0, 0, 0, 4'h0, 0);
    applyStimulus(0, 0, 1, 4'hB, 0);
    applyStimulus(0, 0, 0, 4'h0, 1);
    applyStimulus(0, 0, 0, 4'h0, 0);

    // Flush and reset with three entries and a pending enqueue.
    for (int k = 1; k <= 3; k++) applyStimulus(0, 0, 1, 4'(k), 0);
    applyStimulus(0, 1, 1, 4'd4, 1);
    applyStimulus(0, 0, 0, 4'd0, 0);
    for (int k = 1; k <= 3; k++) applyStimulus(0, 0, 1, 4'(k), 0);
    applyStimulus(1, 0, 1, 4'd4, 1);
    applyStimulus(0, 0, 0, 4'd0, 0);

    // Random traffic with shifting producer/consumer bias.
    for (int phase = 0; phase < 8; phase++) begin
      p_enq = int'($urandom_range(1, 3));
      p_deq = int'($urandom_range(1, 3));
      for (int k = 0; k < 100; k++) begin
        applyStimulus($urandom_range(0, 149) == 0,
                      $urandom_range(0, 39) == 0,
                      $urandom_range(0, 3) < p_enq,
                      4'($urandom_range(0, 15)),
                      $urandom_range(0, 3) < p_deq);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
